store_buffer: RTL and testbench

Posted-store buffer between the EX/MEM pipeline register and the data memory. Stores are accepted in one cycle and drained to the memory write port later: one per cycle whenever the memory port is free, or forcibly when the buffer is full. Loads snoop the buffer, with youngest-match forwarding, so program order is preserved. It removes store-induced stalls from the MEM stage; the data memory's MemWrite/Address/WriteData are driven only by this block.

---
 rtl/sb_pkg.sv | 14 +
 rtl/store_buffer_match.sv | 53 +++++
 rtl/store_buffer.sv | 130 +++++++++++++
 tb/tb_store_buffer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared defaults and types for the posted-store buffer.
package sb_pkg;

  localparam int unsigned SB_DEPTH  = 4;
  localparam int unsigned SB_ADDR_W = 32;
  localparam int unsigned SB_DATA_W = 32;
  localparam int unsigned SB_PTR_W  = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Priority address CAM: youngest buffered entry first, then the in-flight write.
module store_buffer_match
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH,
  parameter int unsigned ADDR_W = SB_ADDR_W,
  parameter int unsigned DATA_W = SB_DATA_W
) (
  input  logic [ADDR_W-1:0]        entry_addr [DEPTH],
  input  logic [DATA_W-1:0]        entry_data [DEPTH],
  input  logic [DEPTH-1:0]         valid,
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH)-1:0] tail,
  input  logic                     inflight_valid,
  input  logic [ADDR_W-1:0]        inflight_addr,
  input  logic [DATA_W-1:0]        inflight_data,
  input  logic                     load_valid,
  input  logic [ADDR_W-1:0]        load_addr,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic              found;
  logic              stop;
  logic [DATA_W-1:0] found_data;
  logic [PTR_W-1:0]  idx;

  // Walk tail-1 down to head; the walk stops once head has been examined.
  always_comb begin
    found      = 1'b0;
    stop       = 1'b0;
    found_data = '0;
    idx        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = tail - PTR_W'(i + 1);
      if (!found && !stop && valid[idx] && entry_addr[idx] == load_addr) begin
        found      = 1'b1;
        found_data = entry_data[idx];
      end
      if (idx == head) stop = 1'b1;
    end
    if (!found && inflight_valid && inflight_addr == load_addr) begin
      found      = 1'b1;
      found_data = inflight_data;
    end
  end

  assign hit  = load_valid && found;
  assign data = hit ? found_data : '0;

endmodule

// File: rtl/store_buffer.sv
// Posted-store buffer: accepts stores in one cycle, drains them to the data
// memory write port, and forwards buffered data to loads.
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH,
  parameter int unsigned ADDR_W = SB_ADDR_W,
  parameter int unsigned DATA_W = SB_DATA_W
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       StoreValid,
  input  logic [ADDR_W-1:0]          StoreAddr,
  input  logic [DATA_W-1:0]          StoreData,
  input  logic                       LoadValid,
  input  logic [ADDR_W-1:0]          LoadAddr,
  output logic                       Full,
  output logic                       Empty,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Overflow,
  output logic                       LoadHit,
  output logic [DATA_W-1:0]          LoadHitData,
  output logic                       MemWrite,
  output logic [ADDR_W-1:0]          MemAddress,
  output logic [DATA_W-1:0]          MemWriteData
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] entry_addr [DEPTH];
  logic [DATA_W-1:0] entry_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              overflow_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [DEPTH-1:0]  valid;

  logic full;
  logic push;
  logic drain;
  logic bypass;

  assign full = (count == CNT_W'(DEPTH));

  // An empty buffer with a free port sends the store straight to the write
  // register, giving the one-cycle store-to-memory latency.
  assign bypass = (count == '0) && StoreValid && !LoadValid;
  assign push   = StoreValid && !full && !bypass;
  assign drain  = (count != '0) && (!LoadValid || full);

  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid[i] = (CNT_W'(PTR_W'(i) - head) < count);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && push) begin
      entry_addr[tail] <= StoreAddr;
      entry_data[tail] <= StoreData;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (StoreValid && full) overflow_q <= 1'b1;

      if (drain) begin
        mem_write_q <= 1'b1;
        mem_addr_q  <= entry_addr[head];
        mem_data_q  <= entry_data[head];
        head        <= head + PTR_W'(1);
      end else if (bypass) begin
        mem_write_q <= 1'b1;
        mem_addr_q  <= StoreAddr;
        mem_data_q  <= StoreData;
      end else begin
        mem_write_q <= 1'b0;
      end

      case ({push, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  store_buffer_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_match (
    .entry_addr     (entry_addr),
    .entry_data     (entry_data),
    .valid          (valid),
    .head           (head),
    .tail           (tail),
    .inflight_valid (mem_write_q),
    .inflight_addr  (mem_addr_q),
    .inflight_data  (mem_data_q),
    .load_valid     (LoadValid),
    .load_addr      (LoadAddr),
    .hit            (LoadHit),
    .data           (LoadHitData)
  );

  assign Full         = full;
  assign Empty        = (count == '0) && !mem_write_q;
  assign Count        = count;
  assign Overflow     = overflow_q;
  assign MemWrite     = mem_write_q;
  assign MemAddress   = mem_addr_q;
  assign MemWriteData = mem_data_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed testbench for store_buffer with hand-computed expectations.
module tb_store_buffer;
  import sb_pkg::*;

  logic                    Clk = 1'b0;
  logic                    Reset = 1'b1;
  logic                    StoreValid = 1'b0;
  logic [SB_ADDR_W-1:0]    StoreAddr = '0;
  logic [SB_DATA_W-1:0]    StoreData = '0;
  logic                    LoadValid = 1'b0;
  logic [SB_ADDR_W-1:0]    LoadAddr = '0;
  logic                    Full;
  logic                    Empty;
  logic [$clog2(SB_DEPTH+1)-1:0] Count;
  logic                    Overflow;
  logic                    LoadHit;
  logic [SB_DATA_W-1:0]    LoadHitData;
  logic                    MemWrite;
  logic [SB_ADDR_W-1:0]    MemAddress;
  logic [SB_DATA_W-1:0]    MemWriteData;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  store_buffer #(
    .DEPTH  (SB_DEPTH),
    .ADDR_W (SB_ADDR_W),
    .DATA_W (SB_DATA_W)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .StoreValid   (StoreValid),
    .StoreAddr    (StoreAddr),
    .StoreData    (StoreData),
    .LoadValid    (LoadValid),
    .LoadAddr     (LoadAddr),
    .Full         (Full),
    .Empty        (Empty),
    .Count        (Count),
    .Overflow     (Overflow),
    .LoadHit      (LoadHit),
    .LoadHitData  (LoadHitData),
    .MemWrite     (MemWrite),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    StoreValid = sv;
    StoreAddr  = sa;
    StoreData  = sd;
    LoadValid  = lv;
    LoadAddr   = la;
    #1;
  endtask

  task automatic check_mem(input string tag, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input int unsigned cnt);
    check({tag, ".we"},    64'(MemWrite), 64'(we));
    check({tag, ".addr"},  64'(MemAddress), 64'(a));
    check({tag, ".data"},  64'(MemWriteData), 64'(d));
    check({tag, ".count"}, 64'(Count), 64'(cnt));
  endtask

  sb_entry_t fill [4];

  initial begin
    fill[0] = '{addr: 32'h1, data: 32'h11};
    fill[1] = '{addr: 32'h2, data: 32'h12};
    fill[2] = '{addr: 32'h3, data: 32'h13};
    fill[3] = '{addr: 32'h4, data: 32'h14};

    // Reset state
    tick(); tick();
    Reset = 1'b0;
    #1;
    check("rst.count", 64'(Count), 64'd0);
    check("rst.full", 64'(Full), 64'd0);
    check("rst.empty", 64'(Empty), 64'd1);
    check("rst.ovf", 64'(Overflow), 64'd0);
    check_mem("rst", 1'b0, 32'h0, 32'h0, 0);

    // Single store into an empty buffer reaches the port next cycle
    drive(1'b1, 32'h10, 32'hAA, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_mem("single", 1'b1, 32'h10, 32'hAA, 0);
    check("single.empty", 64'(Empty), 64'd0);
    tick();
    check_mem("single.idle", 1'b0, 32'h10, 32'hAA, 0);
    check("single.empty2", 64'(Empty), 64'd1);

    // Fill under continuous loads, then forced drain with an overflowing store
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill[i].addr, fill[i].data, 1'b1, 32'h100);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h3);
    check("fill.full", 64'(Full), 64'd1);
    check("fill.count", 64'(Count), 64'd4);
    check("fill.we", 64'(MemWrite), 64'd0);
    check("fill.hit3", 64'(LoadHit), 64'd1);
    check("fill.hitdata3", 64'(LoadHitData), 64'h13);
    drive(1'b1, 32'h5, 32'h15, 1'b1, 32'h100);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h5);
    check_mem("force", 1'b1, 32'h1, 32'h11, 3);
    check("force.ovf", 64'(Overflow), 64'd1);
    check("force.full", 64'(Full), 64'd0);
    check("drop.nohit", 64'(LoadHit), 64'd0);
    check("drop.nohitdata", 64'(LoadHitData), 64'd0);
    tick();
    check_mem("loadblock", 1'b0, 32'h1, 32'h11, 3);
    check("sticky.ovf", 64'(Overflow), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    check_mem("drain2", 1'b1, 32'h2, 32'h12, 2);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    check_mem("midrst", 1'b0, 32'h0, 32'h0, 0);
    check("midrst.ovf", 64'(Overflow), 64'd0);
    check("midrst.empty", 64'(Empty), 64'd1);

    // Youngest-match forwarding over duplicate addresses
    drive(1'b1, 32'h20, 32'h1, 1'b1, 32'h100);
    tick();
    drive(1'b1, 32'h20, 32'h2, 1'b1, 32'h100);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
    check("young.hit", 64'(LoadHit), 64'd1);
    check("young.data", 64'(LoadHitData), 64'h2);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h24);
    check("young.miss", 64'(LoadHit), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h20);
    check("young.novalid", 64'(LoadHit), 64'd0);
    tick();
    check_mem("young.d1", 1'b1, 32'h20, 32'h1, 1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
    check("young.bufwins", 64'(LoadHitData), 64'h2);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    check_mem("young.d2", 1'b1, 32'h20, 32'h2, 0);

    // In-flight forwarding
    drive(1'b1, 32'h30, 32'h7, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h30);
    check_mem("infl", 1'b1, 32'h30, 32'h7, 0);
    check("infl.hit", 64'(LoadHit), 64'd1);
    check("infl.data", 64'(LoadHitData), 64'h7);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h34);
    check("infl.miss", 64'(LoadHit), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h30);
    tick();
    check("infl.gone", 64'(LoadHit), 64'd0);

    // Simultaneous push and drain keeps count and order
    drive(1'b1, 32'h40, 32'h4, 1'b1, 32'h200);
    tick();
    drive(1'b1, 32'h44, 32'h5, 1'b1, 32'h200);
    tick();
    check("pd.count2", 64'(Count), 64'd2);
    drive(1'b1, 32'h48, 32'h6, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_mem("pd.o1", 1'b1, 32'h40, 32'h4, 2);
    tick();
    check_mem("pd.o2", 1'b1, 32'h44, 32'h5, 1);
    tick();
    check_mem("pd.o3", 1'b1, 32'h48, 32'h6, 0);
    tick();
    check("pd.idle", 64'(MemWrite), 64'd0);
    check("pd.empty", 64'(Empty), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
